// File: rtl/nvdla_csb_sequencer.sv
// Issues one HWPE configuration command as a single NVDLA CSB transaction, tracks the
// response, optionally waits for the NVDLA interrupt and guards every wait with a timeout.
module nvdla_csb_sequencer #(
    parameter bit          NPOSTED   = 1'b1,
    parameter int unsigned TIMEOUT_W = 16,
    parameter int unsigned TIMEOUT   = 65535
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,

    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [15:0] cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
    input  logic        cmd_write_i,
    input  logic        cmd_wait_intr_i,

    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,

    output logic        csb2nvdla_valid_o,
    input  logic        csb2nvdla_ready_i,
    output logic [15:0] csb2nvdla_addr_o,
    output logic [31:0] csb2nvdla_wdat_o,
    output logic        csb2nvdla_write_o,
    output logic        csb2nvdla_nposted_o,

    input  logic        nvdla2csb_valid_i,
    input  logic [31:0] nvdla2csb_data_i,
    input  logic        nvdla2csb_wr_complete_i,

    input  logic        intr_i
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_RESP,
        ST_WAIT_INTR,
        ST_DONE
    } state_e;

    localparam bit                   TO_EN   = (TIMEOUT != 0);
    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;

    state_e state_q, state_d;

    logic [15:0]          cmd_addr_q;
    logic [31:0]          cmd_wdata_q;
    logic                 cmd_write_q;
    logic                 cmd_wait_q;
    logic [31:0]          rdata_q;
    logic                 err_q;
    logic                 intr_q;
    logic                 intr_pending_q;
    logic [TIMEOUT_W-1:0] cnt_q;

    logic intr_rise;
    logic rd_done;
    logic wr_done;
    logic timeout_hit;
    logic accept;
    logic capture;
    logic to_fire;
    logic enter_wait;
    logic in_wait;

    assign intr_rise   = intr_i & ~intr_q;
    // A response of the wrong kind for the latched command is simply ignored.
    assign rd_done     = ~cmd_write_q & nvdla2csb_valid_i;
    assign wr_done     = cmd_write_q & nvdla2csb_wr_complete_i;
    assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else if (clear_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        accept              = 1'b0;
        capture             = 1'b0;
        to_fire             = 1'b0;
        cmd_ready_o         = 1'b0;
        busy_o              = 1'b1;
        done_o              = 1'b0;
        csb2nvdla_valid_o   = 1'b0;
        csb2nvdla_addr_o    = '0;
        csb2nvdla_wdat_o    = '0;
        csb2nvdla_write_o   = 1'b0;
        csb2nvdla_nposted_o = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (cmd_valid_i) begin
                    accept  = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                csb2nvdla_valid_o   = 1'b1;
                csb2nvdla_addr_o    = cmd_addr_q;
                csb2nvdla_wdat_o    = cmd_wdata_q;
                csb2nvdla_write_o   = cmd_write_q;
                csb2nvdla_nposted_o = NPOSTED & cmd_write_q;
                if (csb2nvdla_ready_i) begin
                    if (!cmd_write_q || NPOSTED) begin
                        state_d = ST_WAIT_RESP;
                    end else if (cmd_wait_q) begin
                        state_d = ST_WAIT_INTR;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_WAIT_RESP: begin
                // Completion takes priority over a timeout landing on the same cycle.
                if (rd_done || wr_done) begin
                    capture = rd_done;
                    state_d = cmd_wait_q ? ST_WAIT_INTR : ST_DONE;
                end else if (timeout_hit) begin
                    to_fire = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_WAIT_INTR: begin
                if (intr_pending_q || intr_rise) begin
                    state_d = ST_DONE;
                end else if (timeout_hit) begin
                    to_fire = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign in_wait    = (state_q == ST_WAIT_RESP) || (state_q == ST_WAIT_INTR);
    assign enter_wait = ((state_d == ST_WAIT_RESP) || (state_d == ST_WAIT_INTR)) &&
                        (state_d != state_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd_addr_q     <= '0;
            cmd_wdata_q    <= '0;
            cmd_write_q    <= 1'b0;
            cmd_wait_q     <= 1'b0;
            rdata_q        <= '0;
            err_q          <= 1'b0;
            intr_q         <= 1'b0;
            intr_pending_q <= 1'b0;
            cnt_q          <= '0;
        end else if (clear_i) begin
            cmd_addr_q     <= '0;
            cmd_wdata_q    <= '0;
            cmd_write_q    <= 1'b0;
            cmd_wait_q     <= 1'b0;
            rdata_q        <= '0;
            err_q          <= 1'b0;
            intr_q         <= 1'b0;
            intr_pending_q <= 1'b0;
            cnt_q          <= '0;
        end else begin
            intr_q <= intr_i;

            if (accept) begin
                cmd_addr_q  <= cmd_addr_i;
                cmd_wdata_q <= cmd_wdata_i;
                cmd_write_q <= cmd_write_i;
                cmd_wait_q  <= cmd_wait_intr_i;
            end

            // Edges during REQ/WAIT_RESP are remembered so WAIT_INTR cannot miss them.
            if (accept || (state_q == ST_DONE)) begin
                intr_pending_q <= 1'b0;
            end else if ((state_q != ST_IDLE) && intr_rise) begin
                intr_pending_q <= 1'b1;
            end

            if (capture) begin
                rdata_q <= nvdla2csb_data_i;
            end

            if (accept) begin
                err_q <= 1'b0;
            end else if (to_fire) begin
                err_q <= 1'b1;
            end

            if (enter_wait) begin
                cnt_q <= '0;
            end else if (in_wait && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + TIMEOUT_W'(1);
            end
        end
    end

    assign err_o   = err_q;
    assign rdata_o = rdata_q;

endmodule

// File: doc/nvdla_csb_sequencer.md
Name: nvdla_csb_sequencer

Overview:
- Issues one configuration command at a time from the HWPE control FSM (addr / wdata / write / wait_intr) as a single NVDLA CSB transaction.
- Tracks the CSB response (read data or non-posted write completion), optionally waits for the NVDLA interrupt, then signals completion back.
- Sits between the HWPE control FSM and the NVDLA core CSB port, with a timeout guard so a hung core cannot lock up the cluster.

Parameters:
- NPOSTED, 1, 1: writes are issued non-posted and wait for wr_complete; 0: posted writes, complete at CSB accept.
- TIMEOUT_W, 16, width of the wait-state timeout counter.
- TIMEOUT, 65535, max cycles spent in WAIT_RESP or WAIT_INTR before aborting; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous soft clear from HWPE slave
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  command accepted (high only in IDLE)
- cmd_addr_i  in  16  CSB word address
- cmd_wdata_i  in  32  write data
- cmd_write_i  in  1  1 = write, 0 = read
- cmd_wait_intr_i  in  1  wait for NVDLA interrupt after the transaction
- busy_o  out  1  high in any state except IDLE
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  timeout flag, sticky
- rdata_o  out  32  last read data
- csb2nvdla_valid_o  out  1  CSB request valid
- csb2nvdla_ready_i  in  1  CSB request ready
- csb2nvdla_addr_o  out  16  CSB address
- csb2nvdla_wdat_o  out  32  CSB write data
- csb2nvdla_write_o  out  1  CSB write flag
- csb2nvdla_nposted_o  out  1  CSB non-posted flag
- nvdla2csb_valid_i  in  1  read data valid
- nvdla2csb_data_i  in  32  read data
- nvdla2csb_wr_complete_i  in  1  non-posted write complete
- intr_i  in  1  NVDLA interrupt, synchronous to clk_i

Behaviour:
- Reset (rst_ni low, async):
  - State = IDLE.
  - All outputs 0, except cmd_ready_o = 1.
  - rdata_o = 0; latched command registers = 0; timeout counter = 0; intr_pending = 0.
- clear_i: same register values as reset, applied synchronously, in any state. An in-flight CSB request is dropped.
- States: IDLE, REQ, WAIT_RESP, WAIT_INTR, DONE.
- IDLE:
  - cmd_ready_o = 1.
  - On cmd_valid_i: latch addr, wdata, write and wait_intr; clear err_o and intr_pending; go to REQ next cycle.
- REQ:
  - csb2nvdla_valid_o = 1. addr, wdat and write are driven from the latched command.
  - nposted = NPOSTED & write.
  - Valid and payload stay stable until csb2nvdla_ready_i is high.
  - On handshake:
    - Read, or write with NPOSTED=1: go to WAIT_RESP.
    - Posted write: go to WAIT_INTR if wait_intr is set, else DONE.
- WAIT_RESP:
  - Read: nvdla2csb_valid_i captures nvdla2csb_data_i into rdata_o in the same edge.
  - Non-posted write: nvdla2csb_wr_complete_i completes the transaction.
  - On completion go to WAIT_INTR if wait_intr is set, else DONE.
- WAIT_INTR: go to DONE when intr_pending is set or intr_i rises this cycle.
- DONE: done_o = 1 for exactly one cycle, then IDLE. intr_pending is cleared.
- Interrupt capture:
  - A rising edge of intr_i is detected against a registered copy.
  - intr_pending is set on a rising edge seen in any state other than IDLE, so an interrupt arriving during REQ or WAIT_RESP is not lost.
  - A level already high at command accept does not count as an edge.
- Timeout:
  - The counter zeroes on entry to WAIT_RESP or WAIT_INTR and increments every cycle in those states.
  - If TIMEOUT≠0 and the counter equals TIMEOUT-1 with no completion that cycle: set err_o, go to DONE (done_o pulses).
  - Completion arriving in the same cycle as the timeout wins; err_o stays 0.
  - The counter saturates and never wraps.
- Stray inputs:
  - Responses or wr_complete in IDLE, REQ or WAIT_INTR are ignored.
  - A wr_complete during a read, or a read valid during a write, is ignored.
- Latency, minimum:
  - Posted write without interrupt wait: accept → REQ → DONE gives done_o 2 cycles after accept, with ready_i high on the first REQ cycle.
  - Read with a same-cycle response adds 1 cycle.
- cmd_valid_i while busy is not accepted (cmd_ready_o = 0). The requester must hold the command.

Test Plan:
- Read, addr=0x1234, ready_i high immediately, response 0xDEADBEEF 3 cycles after handshake → csb valid for 1 cycle with write=0, nposted=0; rdata_o = 0xDEADBEEF; done_o pulses once; err_o = 0.
- Non-posted write, addr=0x0040, wdata=0x0000_0001, ready_i low for 4 cycles → payload stable through the stall; nposted=1; wr_complete after 2 cycles; done_o 1 cycle later.
- Write with wait_intr=1, intr_i rising during WAIT_RESP before wr_complete → no further wait in WAIT_INTR; done_o the cycle after entering WAIT_INTR.
- TIMEOUT=8, read with no response → err_o = 1 and done_o exactly 8 cycles after entering WAIT_RESP. The next command accept clears err_o.
- Response and timeout in the same cycle (TIMEOUT=8, data on cycle 8) → rdata_o captured, err_o = 0.
- clear_i asserted in REQ, and rst_ni pulsed low in WAIT_INTR → IDLE, cmd_ready_o = 1, all CSB outputs 0, intr_pending = 0. A new command then completes normally.
